// File: rtl/fb_scanout_reader.sv
// ----------------------------------------------------------------------------
// fb_scanout_reader
//   Read side of the pixel framebuffer. Walks the framebuffer in raster order
//   (addr = {y, x}) and streams pixels to a display sink over valid/ready.
//   Start-of-frame and end-of-line markers travel with each pixel.
//
//   Ports
//     clk, reset      rising-edge clock, asynchronous active-low reset
//     enable          level; frames are scanned while high
//     fb_rd_en/addr   read strobe and address to the framebuffer
//     fb_rd_data      read data, valid exactly one cycle after fb_rd_en
//     pix_valid/ready pixel handshake; pix_data/pix_sof/pix_eol from FIFO head
//     frame_done      one-cycle pulse after the last pixel of a frame is taken
//     busy            high while scanning or draining a frame
//     frame_sum       (SCANOUT_CHECKSUM_EN only) mod-2**PIX_W sum of the
//                     pixels of the last completed frame
//
//   Optional feature macro: SCANOUT_CHECKSUM_EN
// ----------------------------------------------------------------------------
module fb_scanout_reader #(
    parameter int FB_W   = 16,
    parameter int FB_H   = 16,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [PIX_W-1:0]  fb_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
`ifdef SCANOUT_CHECKSUM_EN
    output logic [PIX_W-1:0]  frame_sum,
`endif
    output logic              busy
);

    localparam int XW    = $clog2(FB_W);
    localparam int YW    = $clog2(FB_H);
    localparam int ENT_W = PIX_W + 2;   // {data, sof, eol}

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      inflight_q, inflight_d;
    logic [1:0]                meta_q, meta_d;       // {sof, eol} of the read in flight
    logic [1:0][ENT_W-1:0]     mem_q, mem_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      frame_done_q, frame_done_d;
    logic                      busy_q, busy_d;

    logic                      x_last, y_last;
    logic [2:0]                occ;
    logic                      issue, push, pop, last_pop;
    logic [ENT_W-1:0]          head;

    assign x_last = (x_q == XW'(FB_W - 1));
    assign y_last = (y_q == YW'(FB_H - 1));

    // Occupancy = entries held + the read whose data lands next cycle.
    // Keeping this below 2 means every returned word has a free slot.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue = (state_q == S_SCAN) && (occ < 3'd2);
    assign push  = inflight_q;
    assign head  = mem_q[rd_ptr_q];
    assign pop   = pix_valid && pix_ready;

    // In DRAIN no new reads go out, so taking the sole remaining entry with
    // nothing in flight means the frame's last pixel has just been accepted.
    assign last_pop = (state_q == S_DRAIN) && pop && (count_q == 2'd1) && !inflight_q;

    assign fb_rd_en   = issue;
    assign fb_rd_addr = ADDR_W'({y_q, x_q});
    assign pix_valid  = (count_q != 2'd0);
    assign pix_data   = head[ENT_W-1:2];
    assign pix_sof    = head[1];
    assign pix_eol    = head[0];
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    // Scan FSM and raster counters
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (enable) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (issue) begin
                    x_d = x_q + 1'b1;               // power-of-2 width wraps to 0
                    if (x_last) y_d = y_q + 1'b1;
                    if (x_last && y_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    frame_done_d = 1'b1;
                    state_d      = enable ? S_SCAN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d != S_IDLE);
        inflight_d = issue;
        meta_d     = {(x_q == '0) && (y_q == '0), x_last};
    end

    // Two-entry pixel FIFO
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {fb_rd_data, meta_q};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            inflight_q   <= 1'b0;
            meta_q       <= '0;
            mem_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            inflight_q   <= inflight_d;
            meta_q       <= meta_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SCANOUT_CHECKSUM_EN
    logic [PIX_W-1:0] sum_q, sum_d;
    logic [PIX_W-1:0] frame_sum_q, frame_sum_d;

    // The final pixel is folded in on the same cycle it is accepted, so
    // frame_sum lands together with frame_done and the accumulator restarts.
    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if (pop) begin
            sum_d = sum_q + pix_data;
            if (last_pop) begin
                frame_sum_d = sum_q + pix_data;
                sum_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_fb_scanout_reader.sv
// ----------------------------------------------------------------------------
// tb_fb_scanout_reader
//   Scoreboard bench: each test fills a framebuffer model, pushes the raster
//   sequence it expects, and tick() pops/compares every accepted pixel.
// ----------------------------------------------------------------------------
module tb_fb_scanout_reader;

    localparam int FB_W   = 16;
    localparam int FB_H   = 16;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 8;
    localparam int NPIX   = FB_W * FB_H;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              pix_ready = 1'b0;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [PIX_W-1:0]  fb_rd_data = '0;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof, pix_eol, frame_done, busy;
`ifdef SCANOUT_CHECKSUM_EN
    logic [PIX_W-1:0]  frame_sum;
`endif

    fb_scanout_reader #(.FB_W(FB_W), .FB_H(FB_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fb_rd_en   (fb_rd_en),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_data (fb_rd_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .frame_done (frame_done),
`ifdef SCANOUT_CHECKSUM_EN
        .frame_sum  (frame_sum),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Framebuffer model with a one-cycle synchronous read port
    logic [PIX_W-1:0] fb_mem [NPIX];
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb_mem[fb_rd_addr];

    logic [PIX_W+1:0] exp_q [$];
    int n_vec = 0, n_err = 0;
    int issued = 0, accepted = 0, fd_cnt = 0, tick_no = 0;
    logic s_fd, s_busy, s_valid, s_rden;
    logic [ADDR_W-1:0] s_addr;
    logic hold_prev = 1'b0;
    logic [PIX_W+1:0] hold_data;

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++)
            exp_q.push_back({fb_mem[i], 1'(i == 0), 1'((i % FB_W) == FB_W - 1)});
    endtask

    task automatic clear_counts();
        issued = 0; accepted = 0; fd_cnt = 0;
    endtask

    // One clock: sample at negedge, score accepted pixels, then step to posedge+1.
    task automatic tick();
        logic [PIX_W+1:0] e;
        logic [PIX_W+1:0] got;
        @(negedge clk);
        tick_no++;
        s_fd = frame_done; s_busy = busy; s_valid = pix_valid; s_rden = fb_rd_en; s_addr = fb_rd_addr;
        got = {pix_data, pix_sof, pix_eol};
        if (fb_rd_en) begin
            n_vec++;
            if (issued - accepted >= 2) begin
                n_err++;
                $display("FAIL credit: rd_en with %0d outstanding, need < 2", issued - accepted);
            end
        end
        if (hold_prev) begin
            n_vec++;
            if (pix_valid !== 1'b1 || got !== hold_data) begin
                n_err++;
                $display("FAIL hold: valid=%0b head=%h, need valid=1 head=%h", pix_valid, got, hold_data);
            end
        end
        hold_prev = pix_valid && !pix_ready;
        hold_data = got;
        if (pix_valid && pix_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_pixel: got %h, none expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL pixel %0d: got {data,sof,eol}=%h, need %h", accepted, got, e);
                end
            end
            accepted++;
        end
        if (fb_rd_en) issued++;
        if (frame_done) fd_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; pix_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if ({pix_valid, fb_rd_en, busy, frame_done, pix_sof, pix_eol} !== 6'b0 || pix_data !== '0 || fb_rd_addr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%0b rd=%0b busy=%0b fd=%0b data=%h addr=%h, need all 0",
                     pix_valid, fb_rd_en, busy, frame_done, pix_data, fb_rd_addr);
        end
        reset = 1'b1;
        tick(); tick(); tick();
        n_vec++;
        if (s_busy !== 1'b0 || s_rden !== 1'b0) begin
            n_err++;
            $display("FAIL idle_disabled: busy=%0b rd=%0b, need 0 0", s_busy, s_rden);
        end
    endtask

    // fb[a]=a, ready high, enable dropped once pixel 100 is accepted
    task automatic test_raster_enable_drop();
        int first_rd = -1, first_v = -1, iss_end;
        for (int i = 0; i < NPIX; i++) fb_mem[i] = PIX_W'(i);
        clear_counts(); push_frame();
        pix_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 3000 && fd_cnt == 0; c++) begin
            tick();
            if (s_rden && first_rd < 0) first_rd = tick_no;
            if (s_valid && first_v < 0) first_v = tick_no;
            if (accepted >= 101) enable = 1'b0;
        end
        n_vec++;
        if (fd_cnt != 1 || accepted != NPIX || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL raster_frame: frame_done=%0d accepted=%0d left=%0d, need 1 %0d 0", fd_cnt, accepted, exp_q.size(), NPIX);
        end
        n_vec++;
        if (first_v - first_rd != 2) begin
            n_err++;
            $display("FAIL latency: first valid %0d cycles after first read, need 2", first_v - first_rd);
        end
        tick();
        n_vec++;
        if (s_busy !== 1'b0 || s_fd !== 1'b0) begin
            n_err++;
            $display("FAIL after_done: busy=%0b frame_done=%0b, need 0 0", s_busy, s_fd);
        end
        iss_end = issued;
        for (int c = 0; c < 10; c++) tick();
        n_vec++;
        if (issued != iss_end || fd_cnt != 1) begin
            n_err++;
            $display("FAIL stays_idle: reads=%0d frame_done=%0d, need %0d 1", issued, fd_cnt, iss_end);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NPIX; i++) fb_mem[i] = PIX_W'($urandom);
        clear_counts(); push_frame();
        pix_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 4000 && fd_cnt == 0; c++) begin
            tick();
            if (issued > 0) enable = 1'b0;
            // strict 1-0 toggling for the first half, random after
            pix_ready = (accepted < NPIX / 2) ? ~pix_ready : 1'($urandom_range(0, 1));
        end
        pix_ready = 1'b1;
        n_vec++;
        if (fd_cnt != 1 || accepted != NPIX || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL backpressure: frame_done=%0d accepted=%0d left=%0d, need 1 %0d 0", fd_cnt, accepted, exp_q.size(), NPIX);
        end
        tick(); tick();
    endtask

    task automatic test_two_frames();
        int fd_tick = -1, sof_tick = -1;
        for (int i = 0; i < NPIX; i++) fb_mem[i] = PIX_W'(i * 7 + 3);
        clear_counts(); push_frame(); push_frame();
        pix_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 4000 && fd_cnt < 2; c++) begin
            tick();
            if (s_fd && fd_tick < 0) begin fd_tick = tick_no; enable = 1'b0; end
            if (fd_tick >= 0 && sof_tick < 0 && s_valid && pix_sof) sof_tick = tick_no;
        end
        n_vec++;
        if (fd_cnt != 2 || accepted != 2 * NPIX || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL two_frames: frame_done=%0d accepted=%0d left=%0d, need 2 %0d 0", fd_cnt, accepted, exp_q.size(), 2 * NPIX);
        end
        n_vec++;
        if (sof_tick <= fd_tick) begin
            n_err++;
            $display("FAIL second_sof: sof at tick %0d, frame_done at %0d, need sof after", sof_tick, fd_tick);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int first_addr = -1;
        for (int i = 0; i < NPIX; i++) fb_mem[i] = PIX_W'(i);
        clear_counts(); push_frame();
        pix_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 500 && accepted < 50; c++) tick();
        pix_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (pix_valid !== 1'b0 || fb_rd_en !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%0b rd=%0b busy=%0b, need 0 0 0", pix_valid, fb_rd_en, busy);
        end
        exp_q.delete(); hold_prev = 1'b0;
        tick(); tick();
        clear_counts(); push_frame();
        pix_ready = 1'b1; enable = 1'b1;
        reset = 1'b1;
        for (int c = 0; c < 3000 && fd_cnt == 0; c++) begin
            tick();
            if (s_rden && first_addr < 0) first_addr = int'(s_addr);
            if (issued > 0) enable = 1'b0;
        end
        n_vec++;
        if (first_addr != 0 || accepted != NPIX || fd_cnt != 1) begin
            n_err++;
            $display("FAIL restart: first addr=%0d accepted=%0d frame_done=%0d, need 0 %0d 1", first_addr, accepted, fd_cnt, NPIX);
        end
        tick(); tick();
    endtask

`ifdef SCANOUT_CHECKSUM_EN
    task automatic test_checksum();
        logic [PIX_W-1:0] want;
        logic [PIX_W-1:0] seen;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NPIX; i++)
                fb_mem[i] = (k == 0) ? 8'h03 : (k == 1) ? ((i == 0) ? 8'h05 : 8'h00) : PIX_W'($urandom);
            want = '0;
            for (int i = 0; i < NPIX; i++) want = want + fb_mem[i];
            clear_counts(); push_frame();
            pix_ready = 1'b1; enable = 1'b1;
            seen = '1;
            for (int c = 0; c < 3000 && fd_cnt == 0; c++) begin
                tick();
                if (s_fd) seen = frame_sum;
                if (issued > 0) enable = 1'b0;
            end
            n_vec++;
            if (fd_cnt != 1 || seen !== want) begin
                n_err++;
                $display("FAIL checksum%0d: frame_sum=%h frame_done=%0d, need %h 1", k, seen, fd_cnt, want);
            end
            tick(); tick();
            n_vec++;
            if (frame_sum !== want) begin
                n_err++;
                $display("FAIL checksum_hold%0d: frame_sum=%h, need %h", k, frame_sum, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_raster_enable_drop();
        test_backpressure();
        test_two_frames();
        test_reset_mid();
`ifdef SCANOUT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
